// File: rtl/gelu_poly_combiner_if.sv
// Sample and handshake bundle between the cubic stage, the tanh-argument
// combiner and the downstream tanh / final-multiply stage.
interface gelu_poly_combiner_if #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 4
);
   logic [DATA_WIDTH-1:0]         x_in;
   logic                          x_valid;
   logic [DATA_WIDTH-1:0]         cubed_in;
   logic                          cubed_valid;
   logic                          cubed_ovf;
   logic [DATA_WIDTH-1:0]         u_out;
   logic [DATA_WIDTH-1:0]         x_out;
   logic                          valid_out;
   logic                          ovf_out;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic                          err_overrun;
   logic                          err_underrun;

   modport master (
      output x_in, x_valid, cubed_in, cubed_valid, cubed_ovf,
      input  u_out, x_out, valid_out, ovf_out, fifo_level, err_overrun, err_underrun
   );

   modport slave (
      input  x_in, x_valid, cubed_in, cubed_valid, cubed_ovf,
      output u_out, x_out, valid_out, ovf_out, fifo_level, err_overrun, err_underrun
   );
endinterface

// File: rtl/gelu_poly_combiner.sv
// Aligns raw x with its later x^3 and forms the GELU tanh argument
// u = C1*x + C2*x^3 in Q8.16 through a two-stage multiply/add pipeline.
module gelu_poly_combiner #(
   parameter int                    DATA_WIDTH = 24,
   parameter int                    FRAC_BITS  = 16,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] C1         = 24'h00CC42,
   parameter logic [DATA_WIDTH-1:0] C2         = 24'h000922
) (
   input  logic                   clk,
   input  logic                   rst_n,
   gelu_poly_combiner_if.slave    bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = 2 * DATA_WIDTH;

   logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [LW-1:0]          level_r;
   logic                   full_s;
   logic                   empty_s;
   logic                   push_s;
   logic                   pop_s;
   logic [DATA_WIDTH-1:0]  head_s;

   logic signed [PW-1:0]   p1_s;
   logic signed [PW-1:0]   p2_s;
   logic signed [PW-1:0]   p1_r;
   logic signed [PW-1:0]   p2_r;
   logic [DATA_WIDTH-1:0]  x1_r;
   logic                   v1_r;
   logic                   ovf1_r;

   logic signed [PW:0]     sum_s;
   logic signed [PW:0]     shr_s;
   logic [PW-DATA_WIDTH+1:0] hi_s;
   logic                   sat_s;
   logic [DATA_WIDTH-1:0]  u_next_s;

   logic [DATA_WIDTH-1:0]  u_r;
   logic [DATA_WIDTH-1:0]  x_r;
   logic                   valid_r;
   logic                   ovf_r;
   logic                   overrun_r;
   logic                   underrun_r;

   // A pop frees its slot before the push lands, so push-while-full is accepted if a pop coincides.
   assign full_s  = (level_r == LW'(FIFO_DEPTH));
   assign empty_s = (level_r == {LW{1'b0}});
   assign pop_s   = bus.cubed_valid & ~empty_s;
   assign push_s  = bus.x_valid & (~full_s | pop_s);
   assign head_s  = mem_r[rd_ptr_r];

   assign p1_s = $signed({{DATA_WIDTH{head_s[DATA_WIDTH-1]}}, head_s})
               * $signed({{DATA_WIDTH{C1[DATA_WIDTH-1]}}, C1});
   assign p2_s = $signed({{DATA_WIDTH{bus.cubed_in[DATA_WIDTH-1]}}, bus.cubed_in})
               * $signed({{DATA_WIDTH{C2[DATA_WIDTH-1]}}, C2});

   // Sum, floor-shift to Q8.16, then clamp when the upper bits are not a pure sign extension.
   assign sum_s    = {p1_r[PW-1], p1_r} + {p2_r[PW-1], p2_r};
   assign shr_s    = sum_s >>> FRAC_BITS;
   assign hi_s     = shr_s[PW:DATA_WIDTH-1];
   assign sat_s    = ~((&hi_s) | ~(|hi_s));
   assign u_next_s = sat_s ? (shr_s[PW] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}})
                           : shr_s[DATA_WIDTH-1:0];

   // Alignment storage; data words need no reset because level_r gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.x_in;
      end
   end

   // FIFO pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {LW{1'b0}};
         overrun_r  <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         level_r <= level_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
         if (bus.x_valid & full_s & ~bus.cubed_valid) overrun_r  <= 1'b1;
         if (bus.cubed_valid & empty_s)               underrun_r <= 1'b1;
      end
   end

   // Stage 1: coefficient products for the popped sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_r   <= {PW{1'b0}};
         p2_r   <= {PW{1'b0}};
         x1_r   <= {DATA_WIDTH{1'b0}};
         v1_r   <= 1'b0;
         ovf1_r <= 1'b0;
      end else begin
         v1_r <= pop_s;
         if (pop_s) begin
            p1_r   <= p1_s;
            p2_r   <= p2_s;
            x1_r   <= head_s;
            ovf1_r <= bus.cubed_ovf;
         end
      end
   end

   // Stage 2: saturated sum; data outputs hold between valid samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_r     <= {DATA_WIDTH{1'b0}};
         x_r     <= {DATA_WIDTH{1'b0}};
         valid_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         valid_r <= v1_r;
         if (v1_r) begin
            u_r   <= u_next_s;
            x_r   <= x1_r;
            ovf_r <= ovf1_r | sat_s;
         end
      end
   end

   assign bus.u_out        = u_r;
   assign bus.x_out        = x_r;
   assign bus.valid_out    = valid_r;
   assign bus.ovf_out      = ovf_r;
   assign bus.fifo_level   = level_r;
   assign bus.err_overrun  = overrun_r;
   assign bus.err_underrun = underrun_r;
endmodule

// File: tb/tb_gelu_poly_combiner.sv
// Scoreboard bench for gelu_poly_combiner: a queue model of the alignment
// FIFO predicts each output sample, its arrival cycle and the error flags.
module tb_gelu_poly_combiner;
   logic clk;
   logic rst_n;

   gelu_poly_combiner_if #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) b  ();
   gelu_poly_combiner_if #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) b2 ();

   gelu_poly_combiner dut (.clk(clk), .rst_n(rst_n), .bus(b));
   gelu_poly_combiner #(.C1(24'h020000)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(b2));

   typedef struct {
      logic [23:0] u;
      logic [23:0] x;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t        sq[$];
   logic [23:0] mq[$];
   int          checks = 0;
   int          errors = 0;
   int          nc = 0;
   int          max_level = 0;
   bit          exp_ovr = 1'b0;
   bit          exp_und = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_u(input logic [23:0] xv, input logic [23:0] cv,
                                   output logic [23:0] u, output bit sat);
      longint s;
      s = (longint'($signed(xv)) * 64'sd52290 + longint'($signed(cv)) * 64'sd2338) >>> 16;
      sat = 1'b0;
      if (s > 64'sd8388607) begin
         u = 24'h7FFFFF; sat = 1'b1;
      end else if (s < -64'sd8388608) begin
         u = 24'h800000; sat = 1'b1;
      end else begin
         u = s[23:0];
      end
   endfunction

   function automatic logic [23:0] cube_of(input logic [23:0] xv);
      longint sx;
      longint t;
      sx = longint'($signed(xv));
      t  = (sx * sx * sx) >>> 32;
      return t[23:0];
   endfunction

   // Output monitor: every valid_out must match the oldest prediction, on its due cycle.
   always @(negedge clk) begin
      exp_t e;
      nc++;
      if (b.valid_out) begin
         if (sq.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sq.pop_front();
            check("u_out", {8'h00, b.u_out}, {8'h00, e.u});
            check("x_out", {8'h00, b.x_out}, {8'h00, e.x});
            check("ovf_out", {31'd0, b.ovf_out}, {31'd0, e.ovf});
            check("latency", nc, e.due);
         end
      end
   end

   task automatic cyc(input bit xv, input logic [23:0] xd, input bit cv,
                      input logic [23:0] cd, input bit co);
      exp_t        e;
      logic [23:0] u;
      bit          sat;
      b.x_valid = xv; b.x_in = xd; b.cubed_valid = cv; b.cubed_in = cd; b.cubed_ovf = co;
      @(posedge clk);
      if (cv) begin
         if (mq.size() > 0) begin
            e.x = mq.pop_front();
            model_u(e.x, cd, u, sat);
            e.u = u; e.ovf = co | sat; e.due = nc + 2;
            sq.push_back(e);
         end else begin
            exp_und = 1'b1;
         end
      end
      if (xv) begin
         if (mq.size() < 4) mq.push_back(xd);
         else exp_ovr = 1'b1;
      end
      @(negedge clk);
      b.x_valid = 1'b0; b.cubed_valid = 1'b0; b.cubed_ovf = 1'b0;
      if (int'(b.fifo_level) > max_level) max_level = int'(b.fifo_level);
      check("fifo_level", {28'd0, b.fifo_level}, mq.size());
      check("err_overrun", {31'd0, b.err_overrun}, {31'd0, exp_ovr});
      check("err_underrun", {31'd0, b.err_underrun}, {31'd0, exp_und});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_u"}, {8'h00, b.u_out}, 32'd0);
      check({tag, "_x"}, {8'h00, b.x_out}, 32'd0);
      check({tag, "_valid"}, {31'd0, b.valid_out}, 32'd0);
      check({tag, "_ovf"}, {31'd0, b.ovf_out}, 32'd0);
      check({tag, "_level"}, {28'd0, b.fifo_level}, 32'd0);
      check({tag, "_ovr"}, {31'd0, b.err_overrun}, 32'd0);
      check({tag, "_und"}, {31'd0, b.err_underrun}, 32'd0);
   endtask

   task automatic directed(input logic [23:0] xd, input logic [23:0] cd,
                           input logic [23:0] u_req, input string tag);
      cyc(1'b1, xd, 1'b0, 24'h0, 1'b0);
      idle(2);
      cyc(1'b0, 24'h0, 1'b1, cd, 1'b0);
      idle(1);
      check({tag, "_valid"}, {31'd0, b.valid_out}, 32'd1);
      check({tag, "_u"}, {8'h00, b.u_out}, {8'h00, u_req});
      check({tag, "_x"}, {8'h00, b.x_out}, {8'h00, xd});
      idle(1);
      check({tag, "_hold"}, {8'h00, b.u_out}, {8'h00, u_req});
   endtask

   initial begin
      logic [23:0] xs [8];
      rst_n = 1'b0;
      b.x_valid = 1'b0; b.x_in = 24'h0; b.cubed_valid = 1'b0; b.cubed_in = 24'h0; b.cubed_ovf = 1'b0;
      b2.x_valid = 1'b0; b2.x_in = 24'h0; b2.cubed_valid = 1'b0; b2.cubed_in = 24'h0; b2.cubed_ovf = 1'b0;
      #3;
      check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      directed(24'h010000, 24'h010000, 24'h00D564, "one");
      directed(24'h020000, 24'h080000, 24'h01E194, "two");
      directed(24'hFF0000, 24'hFF0000, 24'hFF2A9C, "neg_one");

      // Streaming with the nominal 3-cycle cubic delay.
      for (int i = 0; i < 8; i++) xs[i] = 24'(i * 24'h004000) - 24'h010000 + 24'h000123;
      max_level = 0;
      for (int i = 0; i < 11; i++)
         cyc(i < 8, (i < 8) ? xs[i] : 24'h0, i >= 3, (i >= 3) ? cube_of(xs[i-3]) : 24'h0, 1'b0);
      idle(3);
      check("stream_max_level", max_level, 32'd3);
      check("stream_drained", sq.size(), 32'd0);

      // Overrun then underrun.
      for (int i = 1; i <= 5; i++) cyc(1'b1, 24'(i) << 16, 1'b0, 24'h0, 1'b0);
      for (int i = 1; i <= 4; i++) cyc(1'b0, 24'h0, 1'b1, 24'h001000, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 24'h001000, 1'b0);
      idle(4);
      check("ovr_sticky", {31'd0, b.err_overrun}, 32'd1);
      check("und_sticky", {31'd0, b.err_underrun}, 32'd1);

      // Upstream overflow flag follows only its own sample.
      cyc(1'b1, 24'h008000, 1'b0, 24'h0, 1'b0);
      cyc(1'b1, 24'h00C000, 1'b0, 24'h0, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 24'h002000, 1'b1);
      cyc(1'b0, 24'h0, 1'b1, 24'h006C00, 1'b0);
      idle(3);

      // Saturation on the overridden instance.
      b2.x_valid = 1'b1; b2.x_in = 24'h7FFFFF;
      @(negedge clk); b2.x_valid = 1'b0;
      @(negedge clk); b2.cubed_valid = 1'b1; b2.cubed_in = 24'h7FFFFF;
      @(negedge clk); b2.cubed_valid = 1'b0;
      @(negedge clk);
      check("sat_valid", {31'd0, b2.valid_out}, 32'd1);
      check("sat_u", {8'h00, b2.u_out}, 32'h007FFFFF);
      check("sat_ovf", {31'd0, b2.ovf_out}, 32'd1);

      // Reset with two samples in flight and two entries held.
      for (int i = 1; i <= 4; i++) cyc(1'b1, 24'(i) << 12, 1'b0, 24'h0, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 24'h000100, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 24'h000200, 1'b0);
      #2;
      rst_n = 1'b0;
      sq.delete(); mq.delete(); exp_ovr = 1'b0; exp_und = 1'b0;
      #1;
      check_zero("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      directed(24'h010000, 24'h010000, 24'h00D564, "post_rst");

      for (int i = 0; i < 20 && sq.size() != 0; i++) idle(1);
      check("final_drain", sq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gelu_poly_combiner.md
Name: gelu_poly_combiner

Overview:
- Sits directly downstream of the x^3 cubic stage in the GELU datapath.
- Pairs each raw input x with its later-arriving x^3 using a small alignment FIFO.
- Computes the tanh argument u = C1*x + C2*x^3, with C1 = sqrt(2/pi) and C2 = sqrt(2/pi)*0.044715.
- Outputs u plus the aligned x to the tanh / final-multiply stage.

Parameters:
DATA_WIDTH, 24, signed fixed-point word width
FRAC_BITS, 16, fractional bits (Q8.16)
FIFO_DEPTH, 4, x alignment buffer entries (power of 2, >=4)
C1, 24'h00CC42, sqrt(2/pi) in Q8.16 (52290)
C2, 24'h000922, sqrt(2/pi)*0.044715 in Q8.16 (2338)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
x_in  in  DATA_WIDTH  raw x, presented at the same time as the cubic stage input
x_valid  in  1  push x_in into alignment FIFO
cubed_in  in  DATA_WIDTH  x^3 from cubic stage
cubed_valid  in  1  x^3 valid; pops one x from FIFO
cubed_ovf  in  1  overflow flag from cubic stage, same cycle as cubed_valid
u_out  out  DATA_WIDTH  C1*x + C2*x^3, Q8.16, saturated
x_out  out  DATA_WIDTH  x paired with u_out
valid_out  out  1  u_out/x_out valid
ovf_out  out  1  cubed_ovf of this sample OR saturation in this stage
fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently held
err_overrun  out  1  sticky: push while full
err_underrun  out  1  sticky: pop while empty

Behaviour:
- Reset (async, rst_n low): FIFO empties, pointers and fifo_level = 0. All outputs = 0, including sticky errors. Pipeline valids clear. Assertion mid-operation discards in-flight samples; no valid_out pulses until new cubed_valid after release.
- FIFO push:
  - On x_valid and not full: x_in is written, level+1.
  - On x_valid and full: x_in is dropped, err_overrun set.
- FIFO pop:
  - On cubed_valid and not empty: head entry is read, level-1.
  - On cubed_valid and empty: err_underrun set, sample discarded (no valid_out for it).
  - Pop reads pre-cycle contents; a same-cycle push is never forwarded to the pop.
- Simultaneous push and pop when neither full nor empty: level unchanged.
- Simultaneous push and pop when full: pop frees the slot, push is accepted, no overrun.
- Simultaneous push and pop when empty: underrun, push accepted, level = 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is the registered count.
- Stage 1 (cycle after successful pop): register p1 = signed(x)*signed(C1) and p2 = signed(cubed_in)*signed(C2), each 2*DATA_WIDTH bits. Register x, valid, cubed_ovf alongside.
- Stage 2: s = p1 + p2 in 2*DATA_WIDTH+1 bits, arithmetic shift right by FRAC_BITS (truncate toward -inf).
  - If s exceeds the signed DATA_WIDTH range: u_out = 24'h7FFFFF (positive) or 24'h800000 (negative), sat = 1.
  - ovf_out = stage-1 cubed_ovf | sat.
- Latency: valid_out asserts exactly 2 cycles after an accepted cubed_valid.
- Throughput: one sample per cycle; back-to-back pops produce back-to-back valid_out.
- u_out, x_out, ovf_out hold their last value when valid_out = 0.
- With default constants saturation cannot occur. It is reachable only with larger C1/C2 overrides.
- Nominal system use: cubic stage latency 3, so level peaks at 3 with FIFO_DEPTH 4.

Test Plan:
- Reset then x_valid with x=24'h010000; 3 cycles later cubed_valid with cubed=24'h010000 -> 2 cycles later valid_out=1, u_out=24'h00D564, x_out=24'h010000, ovf_out=0, fifo_level back to 0.
- x=24'h020000, cubed=24'h080000 -> u_out=24'h01E194. Also x=24'hFF0000, cubed=24'hFF0000 -> u_out=24'hFF2A9C.
- Stream 8 consecutive x pushes each followed 3 cycles later by its cube -> 8 consecutive valid_out pulses, correct order, fifo_level never exceeds 3, no error flags.
- 5 pushes with no pops (depth 4) -> level=4, err_overrun=1, 5th x lost. Then cubed_valid when empty after draining 4 -> err_underrun=1, no extra valid_out.
- Override C1=24'h020000; x=24'h7FFFFF, cubed=24'h7FFFFF -> u_out=24'h7FFFFF, ovf_out=1. Separately cubed_ovf=1 with defaults -> ovf_out=1 on that sample only.
- Assert rst_n low while 2 samples are in flight and FIFO holds 2 -> all outputs 0 immediately. After release, no valid_out until a new pop.
